// File: rtl/pdm_mic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_mic_decimator
//
// Generates the PDM microphone clock, samples the 1-bit PDM stream once per
// microphone clock period and decimates it by R = 2**DEC_LOG2 through a
// 3rd-order CIC filter (3 integrators, 3 combs, differential delay 1).
// The comb result is scaled and saturated to a signed SAMPLE_DEPTH-bit sample.
// Everything runs in the wb_clk_i domain.
//
// Optional feature: define MIC_DC_BLOCK_EN to insert a first-order DC blocker
// after saturation. It adds one cycle of latency (5 instead of 4 cycles from
// the wrapping bit strobe to sample_valid).
//
// Ports:
//   wb_clk_i      system clock
//   wb_reset_i    asynchronous, active-high reset
//   enable        1 = run microphone; 0 = mic clock stopped, filter cleared
//   pdm_clk       microphone clock, 50% duty, CLK_DIV wb_clk_i cycles/period
//   pdm_data      PDM bit stream from the microphone
//   audio         signed PCM sample, held between updates
//   sample_valid  one-cycle pulse when audio updates
// -----------------------------------------------------------------------------
module pdm_mic_decimator #(
  parameter int SAMPLE_DEPTH = 8,
  parameter int CLK_DIV      = 4,
  parameter int DEC_LOG2     = 6,
  parameter int DC_SHIFT     = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_reset_i,
  input  logic                    enable,
  output logic                    pdm_clk,
  input  logic                    pdm_data,
  output logic [SAMPLE_DEPTH-1:0] audio,
  output logic                    sample_valid
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int HCW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int W     = 3 * DEC_LOG2 + 2;
  localparam int SHIFT = 3 * DEC_LOG2 + 1 - SAMPLE_DEPTH;

  localparam logic signed [W-1:0] CIC_MAX = W'((2 ** (SAMPLE_DEPTH - 1)) - 1);
  localparam logic signed [W-1:0] CIC_MIN = W'(-(2 ** (SAMPLE_DEPTH - 1)));
  localparam logic signed [SAMPLE_DEPTH-1:0] OUT_MAX = {1'b0, {(SAMPLE_DEPTH-1){1'b1}}};
  localparam logic signed [SAMPLE_DEPTH-1:0] OUT_MIN = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};

  // Scale the comb output down to SAMPLE_DEPTH bits and clamp. The comb range
  // is +/-2**(3*DEC_LOG2), so the positive full-scale value needs the clamp.
  function automatic logic signed [SAMPLE_DEPTH-1:0] sat_cic(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = v >>> SHIFT;
    if (s > CIC_MAX)      return OUT_MAX;
    else if (s < CIC_MIN) return OUT_MIN;
    else                  return s[SAMPLE_DEPTH-1:0];
  endfunction

  // Divider and bit sampling
  logic [HCW-1:0]          div_cnt_q, div_cnt_d;
  logic                    pdm_clk_q, pdm_clk_d;
  logic                    div_wrap;
  logic                    bit_strobe;
  logic signed [W-1:0]     bit_val;

  // CIC state
  logic signed [W-1:0]     integ1_q, integ1_d;
  logic signed [W-1:0]     integ2_q, integ2_d;
  logic signed [W-1:0]     integ3_q, integ3_d;
  logic [DEC_LOG2-1:0]     dec_cnt_q, dec_cnt_d;
  logic                    dec_wrap;
  logic [1:0]              start_cnt_q, start_cnt_d;
  logic signed [W-1:0]     int_prev_q, int_prev_d;
  logic signed [W-1:0]     comb1_q, comb1_d;
  logic signed [W-1:0]     comb1_prev_q, comb1_prev_d;
  logic signed [W-1:0]     comb2_q, comb2_d;
  logic signed [W-1:0]     comb2_prev_q, comb2_prev_d;
  logic signed [W-1:0]     comb3_q, comb3_d;
  // adv marks which comb stage holds a fresh decimated value; keep marks
  // whether that value survived the startup mask. The combs must advance on
  // masked samples too, otherwise their history would be wrong.
  logic [2:0]              adv_q, adv_d;
  logic [2:0]              keep_q, keep_d;

  // Output
  logic signed [SAMPLE_DEPTH-1:0] audio_q, audio_d;
  logic                           valid_q, valid_d;

`ifdef MIC_DC_BLOCK_EN
  localparam int DW = SAMPLE_DEPTH + DC_SHIFT + 2;
  localparam logic signed [DW+1:0] DC_MAX = (DW+2)'((2 ** (DW - 1)) - 1);
  localparam logic signed [DW+1:0] DC_MIN = (DW+2)'(-(2 ** (DW - 1)));
  localparam logic signed [DW-1:0] Y_MAX  = DW'(OUT_MAX) <<< DC_SHIFT;
  localparam logic signed [DW-1:0] Y_MIN  = DW'(OUT_MIN) <<< DC_SHIFT;

  logic signed [SAMPLE_DEPTH-1:0] dc_x_q, dc_x_d;
  logic signed [SAMPLE_DEPTH-1:0] dc_xp_q, dc_xp_d;
  logic signed [DW-1:0]           dc_y_q, dc_y_d;
  logic                           dc_vld_q, dc_vld_d;
  logic signed [DW+1:0]           dc_sum;
  logic signed [DW-1:0]           dc_y_new;
  logic signed [DW-1:0]           dc_out;
`endif

  assign div_wrap   = (div_cnt_q == HCW'(HALF - 1));
  // The strobe is the cycle in which the pdm_clk register is about to fall.
  assign bit_strobe = enable && div_wrap && pdm_clk_q;
  assign dec_wrap   = bit_strobe && (dec_cnt_q == {DEC_LOG2{1'b1}});
  assign bit_val    = pdm_data ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

  // NOTE: every signal written here gets its hold value first, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    pdm_clk_d    = pdm_clk_q;
    integ1_d     = integ1_q;
    integ2_d     = integ2_q;
    integ3_d     = integ3_q;
    dec_cnt_d    = dec_cnt_q;
    start_cnt_d  = start_cnt_q;
    int_prev_d   = int_prev_q;
    comb1_d      = comb1_q;
    comb1_prev_d = comb1_prev_q;
    comb2_d      = comb2_q;
    comb2_prev_d = comb2_prev_q;
    comb3_d      = comb3_q;
    adv_d        = {adv_q[1:0], dec_wrap};
    keep_d       = {keep_q[1:0], dec_wrap && (start_cnt_q == 2'd3)};
    audio_d      = audio_q;
    valid_d      = 1'b0;
`ifdef MIC_DC_BLOCK_EN
    dc_x_d       = dc_x_q;
    dc_xp_d      = dc_xp_q;
    dc_y_d       = dc_y_q;
    dc_vld_d     = 1'b0;
    dc_sum       = ((DW+2)'(dc_x_q) - (DW+2)'(dc_xp_q)) <<< DC_SHIFT;
    dc_sum       = dc_sum + (DW+2)'(dc_y_q) - (DW+2)'(dc_y_q >>> DC_SHIFT);
    if (dc_sum > DC_MAX)      dc_y_new = DC_MAX[DW-1:0];
    else if (dc_sum < DC_MIN) dc_y_new = DC_MIN[DW-1:0];
    else                      dc_y_new = dc_sum[DW-1:0];
    // dc_y carries DC_SHIFT fraction bits so the decay does not stall at
    // 2**DC_SHIFT - 1; the output drops those bits again.
    if (dc_y_new > Y_MAX)      dc_out = Y_MAX;
    else if (dc_y_new < Y_MIN) dc_out = Y_MIN;
    else                       dc_out = dc_y_new;
`endif

    if (!enable) begin
      div_cnt_d    = '0;
      pdm_clk_d    = 1'b0;
      integ1_d     = '0;
      integ2_d     = '0;
      integ3_d     = '0;
      dec_cnt_d    = '0;
      start_cnt_d  = '0;
      int_prev_d   = '0;
      comb1_d      = '0;
      comb1_prev_d = '0;
      comb2_d      = '0;
      comb2_prev_d = '0;
      comb3_d      = '0;
      adv_d        = '0;
      keep_d       = '0;
`ifdef MIC_DC_BLOCK_EN
      dc_x_d       = '0;
      dc_xp_d      = '0;
      dc_y_d       = '0;
`endif
    end else begin
      if (div_wrap) begin
        div_cnt_d = '0;
        pdm_clk_d = ~pdm_clk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      if (bit_strobe) begin
        integ1_d  = integ1_q + bit_val;
        integ2_d  = integ2_q + integ1_d;
        integ3_d  = integ3_q + integ2_d;
        dec_cnt_d = dec_cnt_q + 1'b1;
      end

      // Comb stage 1 captures the decimated integrator value directly.
      if (dec_wrap) begin
        comb1_d    = integ3_d - int_prev_q;
        int_prev_d = integ3_d;
        if (start_cnt_q != 2'd3) start_cnt_d = start_cnt_q + 1'b1;
      end
      if (adv_q[0]) begin
        comb2_d      = comb1_q - comb1_prev_q;
        comb1_prev_d = comb1_q;
      end
      if (adv_q[1]) begin
        comb3_d      = comb2_q - comb2_prev_q;
        comb2_prev_d = comb2_q;
      end

`ifdef MIC_DC_BLOCK_EN
      if (adv_q[2] && keep_q[2]) begin
        dc_x_d   = sat_cic(comb3_q);
        dc_vld_d = 1'b1;
      end
      if (dc_vld_q) begin
        dc_xp_d = dc_x_q;
        dc_y_d  = dc_y_new;
        audio_d = SAMPLE_DEPTH'(dc_out >>> DC_SHIFT);
        valid_d = 1'b1;
      end
`else
      if (adv_q[2] && keep_q[2]) begin
        audio_d = sat_cic(comb3_q);
        valid_d = 1'b1;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      div_cnt_q    <= '0;
      pdm_clk_q    <= 1'b0;
      integ1_q     <= '0;
      integ2_q     <= '0;
      integ3_q     <= '0;
      dec_cnt_q    <= '0;
      start_cnt_q  <= '0;
      int_prev_q   <= '0;
      comb1_q      <= '0;
      comb1_prev_q <= '0;
      comb2_q      <= '0;
      comb2_prev_q <= '0;
      comb3_q      <= '0;
      adv_q        <= '0;
      keep_q       <= '0;
      audio_q      <= '0;
      valid_q      <= 1'b0;
`ifdef MIC_DC_BLOCK_EN
      dc_x_q       <= '0;
      dc_xp_q      <= '0;
      dc_y_q       <= '0;
      dc_vld_q     <= 1'b0;
`endif
    end else begin
      div_cnt_q    <= div_cnt_d;
      pdm_clk_q    <= pdm_clk_d;
      integ1_q     <= integ1_d;
      integ2_q     <= integ2_d;
      integ3_q     <= integ3_d;
      dec_cnt_q    <= dec_cnt_d;
      start_cnt_q  <= start_cnt_d;
      int_prev_q   <= int_prev_d;
      comb1_q      <= comb1_d;
      comb1_prev_q <= comb1_prev_d;
      comb2_q      <= comb2_d;
      comb2_prev_q <= comb2_prev_d;
      comb3_q      <= comb3_d;
      adv_q        <= adv_d;
      keep_q       <= keep_d;
      audio_q      <= audio_d;
      valid_q      <= valid_d;
`ifdef MIC_DC_BLOCK_EN
      dc_x_q       <= dc_x_d;
      dc_xp_q      <= dc_xp_d;
      dc_y_q       <= dc_y_d;
      dc_vld_q     <= dc_vld_d;
`endif
    end
  end

  assign pdm_clk      = pdm_clk_q;
  assign audio        = audio_q;
  assign sample_valid = valid_q;

endmodule
